// File: rtl/lsu_mem_port_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_port_if
//   Request/response handshake bundle between the execute stage (master) and
//   the load/store unit (slave).
//
//   Request channel  (master -> slave): req_valid, req_we, req_funct3,
//                                       req_addr, req_wdata
//                    (slave -> master): req_ready
//   Response channel (slave -> master): resp_valid, resp_rdata, resp_err
//                    (master -> slave): resp_ready
// ---------------------------------------------------------------------------
interface lsu_mem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_mem_port.sv
// ---------------------------------------------------------------------------
// lsu_mem_port
//   Load/store initiator between the core execute stage and a byte-addressed
//   data SRAM with combinational read. One request in flight at a time.
//   Sequence: IDLE -(accept)-> ACCESS -> RESP -(resp handshake)-> IDLE.
//   Faulting requests (illegal funct3, out of range, misaligned) skip ACCESS
//   and never touch the SRAM.
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous active-high reset
//   bus               request/response handshake (slave side)
//   o_mem_w_en        SRAM byte-write enables (0000/0001/0011/1111)
//   o_mem_address     SRAM byte address
//   o_mem_write_data  SRAM write data (not lane-shifted)
//   i_mem_read_data   SRAM read data, byte at o_mem_address in [7:0]
// ---------------------------------------------------------------------------
module lsu_mem_port #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    lsu_mem_port_if.slave     bus,
    output logic [3:0]        o_mem_w_en,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [31:0]       o_mem_write_data,
    input  logic [31:0]       i_mem_read_data
);

    // RV32I funct3 codes for loads/stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_t;

    state_t              r_state;
    logic                r_we;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [31:0]         r_mem_write_data;
    logic [31:0]         r_resp_rdata;
    logic                r_resp_err;

    logic                w_f3_legal;
    logic                w_misaligned;
    logic                w_out_of_range;
    logic                w_req_err;
    logic [3:0]          w_mask;
    logic [31:0]         w_load_data;

    // ------------------------------------------------------------------
    // Request fault check, evaluated on the live request at accept
    // ------------------------------------------------------------------
    always_comb begin
        w_f3_legal = 1'b0;
        case (bus.req_funct3)
            F3_B, F3_H, F3_W: w_f3_legal = 1'b1;
            F3_BU, F3_HU:     w_f3_legal = ~bus.req_we;  // unsigned forms are load-only
            default:          w_f3_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_misaligned = 1'b0;
        case (bus.req_funct3[1:0])
            2'b01:   w_misaligned = bus.req_addr[0];
            2'b10:   w_misaligned = (bus.req_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    // Any address bit above the SRAM range set means out of range
    assign w_out_of_range = ((bus.req_addr >> ADDR_W) != 32'd0);
    assign w_req_err      = ~w_f3_legal | w_misaligned | w_out_of_range;

    // ------------------------------------------------------------------
    // Access decode from the registered request
    // ------------------------------------------------------------------
    always_comb begin
        w_mask = 4'b1111;
        case (r_funct3[1:0])
            2'b00:   w_mask = 4'b0001;
            2'b01:   w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    always_comb begin
        w_load_data = i_mem_read_data;
        case (r_funct3)
            F3_B:    w_load_data = {{24{i_mem_read_data[7]}}, i_mem_read_data[7:0]};
            F3_BU:   w_load_data = {24'h0, i_mem_read_data[7:0]};
            F3_H:    w_load_data = {{16{i_mem_read_data[15]}}, i_mem_read_data[15:0]};
            F3_HU:   w_load_data = {16'h0, i_mem_read_data[15:0]};
            default: w_load_data = i_mem_read_data;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM and registered request/response state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= StIdle;
            r_we             <= 1'b0;
            r_funct3         <= 3'b000;
            r_mem_address    <= '0;
            r_mem_write_data <= 32'h0;
            r_resp_rdata     <= 32'h0;
            r_resp_err       <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.req_valid) begin
                        r_we             <= bus.req_we;
                        r_funct3         <= bus.req_funct3;
                        r_mem_address    <= bus.req_addr[ADDR_W-1:0];
                        r_mem_write_data <= bus.req_wdata;
                        r_resp_rdata     <= 32'h0;
                        r_resp_err       <= w_req_err;
                        // Faults answer straight away without an SRAM cycle
                        r_state          <= w_req_err ? StResp : StAccess;
                    end
                end
                StAccess: begin
                    if (!r_we) begin
                        r_resp_rdata <= w_load_data;
                    end
                    r_state <= StResp;
                end
                StResp: begin
                    if (bus.resp_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: pure decodes of registered state, so the async reset clears
    // the write enables and resp_valid immediately.
    // ------------------------------------------------------------------
    assign bus.req_ready  = (r_state == StIdle);
    assign bus.resp_valid = (r_state == StResp);
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;

    assign o_mem_w_en       = ((r_state == StAccess) && r_we) ? w_mask : 4'b0000;
    assign o_mem_address    = r_mem_address;
    assign o_mem_write_data = r_mem_write_data;

endmodule

// File: tb/tb_lsu_mem_port.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_port
//   Directed and randomized load/store traffic against lsu_mem_port, with an
//   SRAM model on the memory port and a transaction-level byte-array model
//   that predicts every response.
// ---------------------------------------------------------------------------
module tb_lsu_mem_port;

    logic clk = 1'b0;
    logic rst = 1'b0;

    lsu_mem_port_if bus();

    logic [3:0]  mem_w_en;
    logic [15:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    lsu_mem_port #(.ADDR_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .o_mem_w_en       (mem_w_en),
        .o_mem_address    (mem_address),
        .o_mem_write_data (mem_write_data),
        .i_mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 7 + 3) ^ (i >> 8));
    endfunction

    // ---------------- SRAM model on the memory port ----------------
    logic [7:0]  sram [0:65535];
    logic [15:0] a1, a2, a3;
    assign a1 = mem_address + 16'd1;
    assign a2 = mem_address + 16'd2;
    assign a3 = mem_address + 16'd3;
    assign mem_read_data = {sram[a3], sram[a2], sram[a1], sram[mem_address]};

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 65536; i++) sram[i] <= init_byte(i);
        end else begin
            for (int k = 0; k < 4; k++)
                if (mem_w_en[k]) sram[mem_address + 16'(k)] <= mem_write_data[8*k +: 8];
        end
    end

    // ---------------- Reference model ----------------
    logic [7:0] ref_mem [0:65535];

    function automatic void predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                    output logic err, output logic [31:0] data,
                                    output logic [3:0] mask, output int nbytes);
        logic legal;
        int   a;
        int   v;
        nbytes = 1 << f3[1:0];
        legal  = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        err    = !legal || (addr >= 32'h0001_0000) || ((addr % nbytes) != 0);
        a      = int'(addr[15:0]);
        data   = 32'h0;
        mask   = 4'h0;
        if (!err && we) mask = 4'((1 << nbytes) - 1);
        if (!err && !we) begin
            v = 0;
            for (int i = nbytes - 1; i >= 0; i--) v = v * 256 + int'(ref_mem[a + i]);
            data = 32'(v);
            // Signed forms: values in the upper half of the range are negative
            if (f3 == 3'd0 && v >= 128)   data = 32'(v - 256);
            if (f3 == 3'd1 && v >= 32768) data = 32'(v - 65536);
        end
    endfunction

    // One full transaction; stall = extra RESP cycles with resp_ready low
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int stall);
        logic        e_err;
        logic [31:0] e_data;
        logic [3:0]  e_mask;
        int          nb;
        predict(we, f3, addr, e_err, e_data, e_mask, nb);

        bus.resp_ready = (stall == 0);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        check_eq("req_ready_idle", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = $urandom;

        if (!e_err) begin
            check_eq("access_resp_valid", bus.resp_valid, 1'b0);
            check_eq("access_req_ready", bus.req_ready, 1'b0);
            check_eq("access_w_en", mem_w_en, e_mask);
            check_eq("access_addr", mem_address, addr[15:0]);
            check_eq("access_wdata", mem_write_data, wdata);
            @(posedge clk); #1;
        end

        check_eq("resp_valid", bus.resp_valid, 1'b1);
        check_eq("resp_err", bus.resp_err, e_err);
        check_eq("resp_rdata", bus.resp_rdata, e_data);
        check_eq("resp_w_en", mem_w_en, 4'h0);

        for (int i = 0; i < stall; i++) begin
            // A request offered under back-pressure must be ignored
            if (i == 1) begin
                bus.req_valid  = 1'b1;
                bus.req_we     = 1'b1;
                bus.req_funct3 = 3'd2;
                bus.req_addr   = 32'h0000_0100;
            end
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            check_eq("stall_resp_valid", bus.resp_valid, 1'b1);
            check_eq("stall_rdata", bus.resp_rdata, e_data);
            check_eq("stall_err", bus.resp_err, e_err);
            check_eq("stall_req_ready", bus.req_ready, 1'b0);
            check_eq("stall_w_en", mem_w_en, 4'h0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("back_idle_req_ready", bus.req_ready, 1'b1);
        check_eq("back_idle_resp_valid", bus.resp_valid, 1'b0);

        if (!e_err && we)
            for (int i = 0; i < nb; i++) ref_mem[int'(addr[15:0]) + i] = wdata[8*i +: 8];
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, bus.req_ready, 1'b1);
        check_eq({tag, "_resp_valid"}, bus.resp_valid, 1'b0);
        check_eq({tag, "_resp_rdata"}, bus.resp_rdata, 32'h0);
        check_eq({tag, "_resp_err"}, bus.resp_err, 1'b0);
        check_eq({tag, "_w_en"}, mem_w_en, 4'h0);
        check_eq({tag, "_addr"}, mem_address, 16'h0);
        check_eq({tag, "_wdata"}, mem_write_data, 32'h0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        we;
        int          stall;
        logic [2:0]  legal_f3 [5];
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);

        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Word store / load
        do_req(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 0);
        do_req(1'b0, 3'd2, 32'h0000_0100, 32'h0, 0);
        check_eq("lw_literal", bus.resp_rdata, 32'hDEAD_BEEF);
        // Byte store / signed and unsigned loads
        do_req(1'b1, 3'd0, 32'h0000_0203, 32'h0000_00F0, 0);
        do_req(1'b0, 3'd0, 32'h0000_0203, 32'h0, 0);
        check_eq("lb_literal", bus.resp_rdata, 32'hFFFF_FFF0);
        do_req(1'b0, 3'd4, 32'h0000_0203, 32'h0, 0);
        // Halfword store / loads
        do_req(1'b1, 3'd1, 32'h0000_0302, 32'h0000_8001, 0);
        do_req(1'b0, 3'd1, 32'h0000_0302, 32'h0, 0);
        check_eq("lh_literal", bus.resp_rdata, 32'hFFFF_8001);
        do_req(1'b0, 3'd5, 32'h0000_0302, 32'h0, 0);
        // Faulting requests, then confirm memory untouched
        do_req(1'b0, 3'd2, 32'h0000_0102, 32'h0, 0);
        do_req(1'b1, 3'd1, 32'h0000_0301, 32'h1234_5678, 0);
        do_req(1'b0, 3'd3, 32'h0000_0100, 32'h0, 0);
        do_req(1'b1, 3'd4, 32'h0000_0100, 32'h1111_1111, 0);
        do_req(1'b0, 3'd2, 32'h0001_0000, 32'h0, 0);
        do_req(1'b1, 3'd2, 32'h0001_0100, 32'h2222_2222, 0);
        do_req(1'b0, 3'd2, 32'h0000_0100, 32'h0, 0);
        do_req(1'b0, 3'd2, 32'h0000_0300, 32'h0, 0);
        // Top byte of the address space
        do_req(1'b1, 3'd0, 32'h0000_FFFF, 32'h0000_00A5, 0);
        do_req(1'b0, 3'd4, 32'h0000_FFFF, 32'h0, 0);
        // Back-pressure on a load response
        do_req(1'b0, 3'd2, 32'h0000_0100, 32'h0, 5);
        do_req(1'b0, 3'd2, 32'h0000_0100, 32'h0, 0);

        // Reset pulse during the ACCESS cycle of a store
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h0000_0500;
        bus.req_wdata  = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check_eq("rstpulse_w_en_before", mem_w_en, 4'hF);
        rst = 1'b1;
        #1 check_reset_outputs("rstpulse");
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rstpulse_idle", bus.req_ready, 1'b1);
        do_req(1'b0, 3'd2, 32'h0000_0500, 32'h0, 0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 4) != 0) ? legal_f3[$urandom_range(0, 4)]
                                             : 3'($urandom_range(0, 7));
            addr = 32'h0000_0400 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0 && f3[1:0] != 2'b11)
                addr = addr & ~(32'((1 << f3[1:0]) - 1));
            if ($urandom_range(0, 15) == 0) addr = 32'h0000_FFFC + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) addr[31:16] = 16'($urandom_range(1, 65535));
            stall = ($urandom_range(0, 7) < 6) ? 0 : $urandom_range(1, 3);
            do_req(we, f3, addr, $urandom, stall);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
